// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
// Module   : branch_predictor
// Brief    : Direct-mapped tagged predictor with 2-bit counters, target store,
//            registered mispredict flag and saturating statistics counters.
// Revision : 1.0
// ============================================================================
module branch_predictor #(
    parameter int PC_W  = 32,
    parameter int IDX_W = 6,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PC_W-1:0]  pc_f,
    output logic             pred_taken,
    output logic [PC_W-1:0]  pred_target,
    input  logic             upd_valid,
    input  logic [PC_W-1:0]  upd_pc,
    input  logic             upd_taken,
    input  logic [PC_W-1:0]  upd_target,
    input  logic             upd_pred_taken,
    input  logic [PC_W-1:0]  upd_pred_target,
    output logic             mispredict,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam int c_TAG_W = PC_W - IDX_W - 2;
    localparam int c_DEPTH = 1 << IDX_W;

    logic [c_DEPTH-1:0] r_valid;
    logic [c_TAG_W-1:0] r_tag    [c_DEPTH];
    logic [1:0]         r_ctr    [c_DEPTH];
    logic [PC_W-1:0]    r_target [c_DEPTH];

    logic               r_mispredict;
    logic [CNT_W-1:0]   r_branch_cnt;
    logic [CNT_W-1:0]   r_mispred_cnt;

    logic [IDX_W-1:0]   w_f_idx;
    logic [c_TAG_W-1:0] w_f_tag;
    logic               w_f_hit;
    logic               w_pred_taken;
    logic [IDX_W-1:0]   w_u_idx;
    logic [c_TAG_W-1:0] w_u_tag;
    logic               w_u_hit;
    logic               w_mis;

    // Lookup reads the registered table only, so a same-index update is seen next cycle.
    assign w_f_idx      = pc_f[IDX_W+1:2];
    assign w_f_tag      = pc_f[PC_W-1:IDX_W+2];
    assign w_f_hit      = r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);
    assign w_pred_taken = w_f_hit && r_ctr[w_f_idx][1];

    assign pred_taken   = w_pred_taken;
    assign pred_target  = w_pred_taken ? r_target[w_f_idx] : (pc_f + PC_W'(4));

    assign w_u_idx = upd_pc[IDX_W+1:2];
    assign w_u_tag = upd_pc[PC_W-1:IDX_W+2];
    assign w_u_hit = r_valid[w_u_idx] && (r_tag[w_u_idx] == w_u_tag);

    assign w_mis = upd_valid &&
                   ((upd_taken != upd_pred_taken) ||
                    (upd_taken && upd_pred_taken && (upd_target != upd_pred_target)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            for (int i = 0; i < c_DEPTH; i++) begin
                r_tag[i]    <= '0;
                r_ctr[i]    <= 2'b01;
                r_target[i] <= '0;
            end
        end else if (upd_valid) begin
            if (w_u_hit) begin
                if (upd_taken) begin
                    if (r_ctr[w_u_idx] != 2'b11) begin
                        r_ctr[w_u_idx] <= r_ctr[w_u_idx] + 2'b01;
                    end
                    r_target[w_u_idx] <= upd_target;
                end else if (r_ctr[w_u_idx] != 2'b00) begin
                    r_ctr[w_u_idx] <= r_ctr[w_u_idx] - 2'b01;
                end
            end else if (upd_taken) begin
                r_valid[w_u_idx]  <= 1'b1;
                r_tag[w_u_idx]    <= w_u_tag;
                r_ctr[w_u_idx]    <= 2'b10;
                r_target[w_u_idx] <= upd_target;
            end
        end
    end

    // Statistics stop at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mispredict  <= 1'b0;
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else begin
            r_mispredict <= w_mis;
            if (upd_valid && (r_branch_cnt != {CNT_W{1'b1}})) begin
                r_branch_cnt <= r_branch_cnt + CNT_W'(1);
            end
            if (w_mis && (r_mispred_cnt != {CNT_W{1'b1}})) begin
                r_mispred_cnt <= r_mispred_cnt + CNT_W'(1);
            end
        end
    end

    assign mispredict  = r_mispredict;
    assign branch_cnt  = r_branch_cnt;
    assign mispred_cnt = r_mispred_cnt;

endmodule
`default_nettype wire

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Front-end counterpart to the execute-stage branch resolution logic.
- Predicts taken/not-taken and the target for the fetch PC.
- Accepts the resolved outcome (the branch decision bit, the actual target, and what was predicted) to train its tables.
- Flags mispredictions one cycle later and keeps saturating statistics counters.

Parameters:
- PC_W, 32, PC width in bits.
- IDX_W, 6, index width; the table has 2^IDX_W entries.
- CNT_W, 16, width of each statistics counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- pc_f  input  PC_W  fetch-stage PC to predict.
- pred_taken  output  1  prediction for pc_f (combinational).
- pred_target  output  PC_W  predicted next PC for pc_f (combinational).
- upd_valid  input  1  resolved conditional branch present this cycle.
- upd_pc  input  PC_W  PC of the resolved branch.
- upd_taken  input  1  actual outcome (resolved branch decision bit).
- upd_target  input  PC_W  actual branch target.
- upd_pred_taken  input  1  prediction that was made for this branch.
- upd_pred_target  input  PC_W  target that was predicted for this branch.
- mispredict  output  1  registered; 1 the cycle after a mispredicted update.
- branch_cnt  output  CNT_W  number of updates seen, saturating.
- mispred_cnt  output  CNT_W  number of mispredictions, saturating.

Behaviour:
- Table entry: valid (1), tag (PC_W-IDX_W-2 bits), 2-bit counter, target (PC_W).
- Index = pc[IDX_W+1:2]; tag = pc[PC_W-1:IDX_W+2]; pc[1:0] is ignored.
- Async reset (rst_n=0): all valid=0, all counters=2'b01, all targets=0, mispredict=0, branch_cnt=0, mispred_cnt=0. Outputs take these values immediately, without waiting for a clock.
- Lookup (combinational on pc_f):
  - hit = valid[idx] & (tag[idx]==tag(pc_f)).
  - pred_taken = hit & ctr[idx][1].
  - pred_target = pred_taken ? target[idx] : pc_f+4, with pc_f+4 wrapping modulo 2^PC_W.
- Update (rising edge, when upd_valid=1), with uhit = tag hit for upd_pc:
  - uhit & upd_taken: ctr increments, saturating at 2'b11; target <= upd_target.
  - uhit & !upd_taken: ctr decrements, saturating at 2'b00; target is unchanged.
  - !uhit & upd_taken: allocate/replace the entry: valid=1, tag=tag(upd_pc), ctr=2'b10, target=upd_target.
  - !uhit & !upd_taken: no table change (not-taken branches are not allocated).
- Misprediction:
  - mis = upd_valid & ((upd_taken != upd_pred_taken) | (upd_taken & upd_pred_taken & (upd_target != upd_pred_target))).
  - mispredict <= mis; it is 0 in any cycle after upd_valid=0.
  - Latency is exactly 1 cycle; the output is high for exactly one cycle per event.
- Statistics:
  - branch_cnt += 1 per update; mispred_cnt += 1 per mis.
  - Both hold at all-ones (2^CNT_W-1) and never wrap.
- Read/write collision: if pc_f and upd_pc map to the same index in the same cycle, the lookup returns the pre-update (old) entry. There is no bypass; the new value is visible the next cycle.
- upd_valid=0: no state changes except mispredict <= 0.
- Reset asserted mid-operation: every entry and counter clears at once; a pending mispredict is lost.
- X-safety: when upd_valid=0, the upd_* inputs are don't-care and must not affect state.

Test Plan:
- Reset then pc_f=0x00000100 -> pred_taken=0, pred_target=0x00000104; branch_cnt=0, mispred_cnt=0, mispredict=0.
- Update pc=0x100, taken=1, target=0x80, pred_taken=0 -> next cycle mispredict=1 for one cycle, mispred_cnt=1; pc_f=0x100 then gives pred_taken=1 (ctr=10), pred_target=0x80.
- Same entry: two not-taken updates -> ctr 10->01->00, pred_taken=0; a third not-taken update holds at 00; three taken updates -> 01, 10, 11, and further taken updates hold at 11.
- Aliasing: pc 0x100 allocated taken, then taken update at pc 0x10100 (same index, different tag) -> entry replaced; pc_f=0x100 gives pred_taken=0, pred_target=0x104.
- Collision: pc_f=upd_pc=0x200 with a first-time taken update -> pred_taken=0 in that cycle, 1 in the next cycle.
- Target mismatch: upd_taken=1, upd_pred_taken=1, upd_pred_target=0x40, upd_target=0x44 -> mispredict=1; drive 2^CNT_W+3 updates -> counters saturate at 0xFFFF; assert rst_n=0 mid-stream -> all outputs return to reset values with no clock edge.
